// File: rtl/mul_div_unit.sv
// Multi-cycle MIPS MULT/MULTU/DIV/DIVU unit: 2-cycle multiply, 32-iteration restoring divide, one HI/LO write pulse.
// Optional macro MDU_DIV_SHORTCUT_EN: skip the divide loop when the divisor is zero or |dividend| < |divisor|.
module mul_div_unit #(
  parameter int DIV_ITER = 32
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic        w_hi,
  output logic [31:0] hi_data,
  output logic        w_lo,
  output logic [31:0] lo_data
);
  localparam int CW = $clog2(DIV_ITER);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t        r_state, w_next;
  logic          r_sgn;
  logic [31:0]   r_a, r_b, r_dmag, r_hi, r_lo;
  logic [63:0]   r_rem;
  logic [CW-1:0] r_cnt;

  logic          w_accept, w_in_sgn, w_short, w_ge, w_div0;
  logic [31:0]   w_in_amag, w_in_bmag, w_diff, w_q_mag, w_r_mag, w_div_q, w_div_r;
  logic [63:0]   w_mx_a, w_mx_b, w_prod, w_rem_nx;
  logic [64:0]   w_sh;

  assign w_accept  = (r_state == S_IDLE) && start && !flush;
  assign w_in_sgn  = ~op[0];
  assign w_in_amag = (w_in_sgn && src_a[31]) ? -src_a : src_a;
  assign w_in_bmag = (w_in_sgn && src_b[31]) ? -src_b : src_b;

`ifdef MDU_DIV_SHORTCUT_EN
  assign w_short = op[1] && ((src_b == 32'd0) || (w_in_amag < w_in_bmag));
`else
  assign w_short = 1'b0;
`endif

  // Low 64 bits of the 64x64 product equal the exact signed/unsigned 32x32 product.
  assign w_mx_a = r_sgn ? {{32{r_a[31]}}, r_a} : {32'd0, r_a};
  assign w_mx_b = r_sgn ? {{32{r_b[31]}}, r_b} : {32'd0, r_b};
  assign w_prod = w_mx_a * w_mx_b;

  // Restoring step: shifted remainder can reach 33 bits, so compare with the carry bit.
  assign w_sh     = {r_rem, 1'b0};
  assign w_ge     = w_sh[64:32] >= {1'b0, r_dmag};
  assign w_diff   = w_sh[63:32] - r_dmag;
  assign w_rem_nx = w_ge ? {w_diff, w_sh[31:1], 1'b1} : w_sh[63:0];

  assign w_q_mag = w_rem_nx[31:0];
  assign w_r_mag = w_rem_nx[63:32];
  assign w_div0  = (r_b == 32'd0);
  assign w_div_q = w_div0 ? 32'hFFFF_FFFF :
                   (r_sgn && (r_a[31] ^ r_b[31])) ? -w_q_mag : w_q_mag;
  assign w_div_r = w_div0 ? r_a : (r_sgn && r_a[31]) ? -w_r_mag : w_r_mag;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = !op[1] ? S_MUL : (w_short ? S_DONE : S_DIV);
      S_MUL:  w_next = S_DONE;
      S_DIV:  if (r_cnt == '0) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (r_state != S_IDLE && flush) w_next = S_IDLE;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_sgn  <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_dmag <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else if (w_accept) begin
      r_sgn  <= w_in_sgn;
      r_a    <= src_a;
      r_b    <= src_b;
      r_dmag <= w_in_bmag;
      r_rem  <= {32'd0, w_in_amag};
      r_cnt  <= CW'(DIV_ITER - 1);
      if (w_short) begin
        r_hi <= src_a;
        r_lo <= (src_b == 32'd0) ? 32'hFFFF_FFFF : 32'd0;
      end
    end else if (!flush) begin
      case (r_state)
        S_MUL: begin
          r_hi <= w_prod[63:32];
          r_lo <= w_prod[31:0];
        end
        S_DIV: begin
          r_rem <= w_rem_nx;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) begin
            r_hi <= w_div_r;
            r_lo <= w_div_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign w_hi    = (r_state == S_DONE) && !flush;
  assign w_lo    = (r_state == S_DONE) && !flush;
  assign hi_data = r_hi;
  assign lo_data = r_lo;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, random ops vs arithmetic model, flush/reset sequences.
module tb_mul_div_unit;
  logic        clock, resetn, start, flush;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, w_hi, w_lo;
  logic [31:0] hi_data, lo_data;

  int checks = 0;
  int failures = 0;

  mul_div_unit dut (
    .clock(clock), .resetn(resetn), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .flush(flush), .busy(busy),
    .w_hi(w_hi), .hi_data(hi_data), .w_lo(w_lo), .lo_data(lo_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain wide arithmetic on the architectural definition.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint xa, xb, q, r;
    int ia, ib;
    ia = a; ib = b;
    xa = o[0] ? longint'({32'd0, a}) : longint'(ia);
    xb = o[0] ? longint'({32'd0, b}) : longint'(ib);
    if (!o[1]) return 64'(xa * xb);
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    q = xa / xb;
    r = xa % xb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint ma, mb;
    int ia, ib;
    ia = a; ib = b;
    ma = o[0] ? longint'({32'd0, a}) : longint'(ia);
    mb = o[0] ? longint'({32'd0, b}) : longint'(ib);
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    if (!o[1]) return 1;
`ifdef MDU_DIV_SHORTCUT_EN
    if (b == 32'd0 || ma < mb) return 0;
`endif
    return 32 + 0 * int'(ma + mb);
  endfunction

  // Issues one op; lat = edges after the start edge before the pulse is seen. junk>0 keeps
  // start high with a different op for that many cycles to prove start is ignored while busy.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int junk,
                        output logic [31:0] hi, output logic [31:0] lo, output int lat, output int npulse);
    bit done;
    @(negedge clock);
    op = o; src_a = a; src_b = b; start = 1'b1;
    #1 check("busy_low_in_start_cycle", 64'(busy), 64'd0);
    @(posedge clock);
    @(negedge clock);
    if (junk > 0) begin op = 2'b00; src_a = 32'd3; src_b = 32'd4; end
    else start = 1'b0;
    lat = -1; npulse = 0; hi = '0; lo = '0; done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      if (w_hi || w_lo) begin
        npulse++;
        if (lat < 0) lat = k;
        hi = hi_data; lo = lo_data;
        if (w_hi !== w_lo) check("whi_eq_wlo", 64'(w_lo), 64'(w_hi));
      end
      if (!busy) done = 1'b1;
      else begin
        if (k + 1 >= junk) start = 1'b0;
        @(negedge clock);
      end
    end
    start = 1'b0;
    if (!done) check("timeout_busy_never_dropped", 64'(busy), 64'd0);
  endtask

  vec_t tbl[8];
  logic [31:0] hi, lo, sv_hi, sv_lo;
  int lat, np;
  logic [63:0] e;
  bit seen;

  initial begin
    tbl[0] = '{2'b00, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA};
    tbl[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
    tbl[4] = '{2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
    tbl[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    tbl[6] = '{2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
    tbl[7] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};

    resetn = 1'b1; start = 1'b0; flush = 1'b0; op = '0; src_a = '0; src_b = '0;
    #2 resetn = 1'b0;
    #5;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_w_hi", 64'(w_hi), 64'd0);
    check("reset_w_lo", 64'(w_lo), 64'd0);
    check("reset_hi_data", 64'(hi_data), 64'd0);
    check("reset_lo_data", 64'(lo_data), 64'd0);
    @(negedge clock); resetn = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, 0, hi, lo, lat, np);
      check($sformatf("vec%0d_hi", i), 64'(hi), 64'(tbl[i].hi));
      check($sformatf("vec%0d_lo", i), 64'(lo), 64'(tbl[i].lo));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat(tbl[i].op, tbl[i].a, tbl[i].b)));
      check($sformatf("vec%0d_pulses", i), 64'(np), 64'd1);
    end

    // Start with flush in IDLE is ignored.
    @(negedge clock); start = 1'b1; flush = 1'b1; op = 2'b00; src_a = 32'd9; src_b = 32'd9;
    @(negedge clock); start = 1'b0; flush = 1'b0;
    check("start_with_flush_ignored", 64'(busy), 64'd0);

    // Flush mid-divide: no pulse, outputs held.
    sv_hi = hi_data; sv_lo = lo_data; seen = 1'b0;
    @(negedge clock); op = 2'b10; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    @(negedge clock); start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (w_hi || w_lo) seen = 1'b1;
    end
    flush = 1'b1;
    @(negedge clock); flush = 1'b0;
    #1;
    check("flush_div_busy", 64'(busy), 64'd0);
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (w_hi || w_lo) seen = 1'b1;
    end
    check("flush_div_no_pulse", 64'(seen), 64'd0);
    check("flush_div_hi_held", 64'(hi_data), 64'(sv_hi));
    check("flush_div_lo_held", 64'(lo_data), 64'(sv_lo));

    // Flush during DONE suppresses that cycle's pulse.
    @(negedge clock); op = 2'b01; src_a = 32'd6; src_b = 32'd7; start = 1'b1;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    check("done_pulse_before_flush", 64'(w_hi), 64'd1);
    flush = 1'b1;
    #1;
    check("done_flush_w_hi", 64'(w_hi), 64'd0);
    check("done_flush_w_lo", 64'(w_lo), 64'd0);
    @(negedge clock); flush = 1'b0;
    check("done_flush_idle", 64'(busy), 64'd0);

    // Asynchronous reset mid-divide.
    @(negedge clock); op = 2'b11; src_a = 32'd12345; src_b = 32'd17; start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (5) @(posedge clock);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_w_hi", 64'(w_hi), 64'd0);
    check("async_rst_hi_data", 64'(hi_data), 64'd0);
    check("async_rst_lo_data", 64'(lo_data), 64'd0);
    @(negedge clock); resetn = 1'b1;
    run_op(2'b00, 32'd6, 32'hFFFF_FFF9, 0, hi, lo, lat, np);
    check("post_rst_mult", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFD6);

    // Start held high while busy must not launch a second op.
    run_op(2'b11, 32'd100, 32'd7, 3, hi, lo, lat, np);
    check("start_busy_result", {hi, lo}, {32'd2, 32'd14});
    check("start_busy_latency", 64'(lat), 64'(exp_lat(2'b11, 32'd100, 32'd7)));
    check("start_busy_pulses", 64'(np), 64'd1);
    @(negedge clock);
    check("start_busy_no_relaunch", 64'(busy), 64'd0);

    // Random operations against the model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0] ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 50));
        2: rb = -32'($urandom_range(1, 50));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 4) == 0) ra = 32'($urandom_range(0, 40));
      e = model(ro, ra, rb);
      run_op(ro, ra, rb, 0, hi, lo, lat, np);
      check($sformatf("rnd%0d_op%0d_%h_%h_result", i, ro, ra, rb), {hi, lo}, e);
      check($sformatf("rnd%0d_latency", i), 64'(lat), 64'(exp_lat(ro, ra, rb)));
      check($sformatf("rnd%0d_pulses", i), 64'(np), 64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
